sc_lane_shifter: RTL and testbench

- Vehicle-lane row register for one road lane of the frogger playfield; consumes the one-cycle speed tick from the lane's velocity tick generator.
- Rotates a LANE_WIDTH-bit occupancy pattern one cell per tick, with load, pause and a sticky frog-collision halt.
- Its output row drives the display/matrix mux and the game-over logic.

---
 rtl/sc_lane_shifter_if.sv | 27 ++
 rtl/sc_lane_shifter.sv | 84 ++++++++
 tb/tb_sc_lane_shifter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sc_lane_shifter_if.sv
// Lane shifter control/data bundle: tick, load, pause and frog inputs plus
// the registered row, hit, step and state outputs.
interface sc_lane_shifter_if #(
    parameter int LANE_WIDTH = 8
);
    logic                  SC_LANE_TICK_In;
    logic                  SC_LANE_LOAD_In;
    logic [LANE_WIDTH-1:0] SC_LANE_PATTERN_In;
    logic                  SC_LANE_PAUSE_In;
    logic [LANE_WIDTH-1:0] SC_LANE_FROG_In;
    logic [LANE_WIDTH-1:0] SC_LANE_Out;
    logic                  SC_LANE_HIT_Out;
    logic                  SC_LANE_STEP_Out;
    logic [1:0]            SC_LANE_STATE_Out;

    modport master (
        output SC_LANE_TICK_In, SC_LANE_LOAD_In, SC_LANE_PATTERN_In,
               SC_LANE_PAUSE_In, SC_LANE_FROG_In,
        input  SC_LANE_Out, SC_LANE_HIT_Out, SC_LANE_STEP_Out, SC_LANE_STATE_Out
    );

    modport slave (
        input  SC_LANE_TICK_In, SC_LANE_LOAD_In, SC_LANE_PATTERN_In,
               SC_LANE_PAUSE_In, SC_LANE_FROG_In,
        output SC_LANE_Out, SC_LANE_HIT_Out, SC_LANE_STEP_Out, SC_LANE_STATE_Out
    );
endinterface

// File: rtl/sc_lane_shifter.sv
// Frogger vehicle-lane row: circular occupancy register rotated on each speed
// tick, with load, pause and a sticky frog-collision halt.
module sc_lane_shifter #(
    parameter int                    LANE_WIDTH   = 8,
    parameter bit                    DIR          = 1'b0,
    parameter logic [LANE_WIDTH-1:0] INIT_PATTERN = 8'b0000_0011
) (
    input  logic                SC_LANE_CLOCK_50,
    input  logic                SC_LANE_RESET,
    sc_lane_shifter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        HALT   = 2'b11
    } state_t;

    state_t                state_p1, state_p0;
    logic [LANE_WIDTH-1:0] row_p1, row_p0;
    logic                  hit_p1, hit_p0;
    logic                  step_p1, step_p0;

    function automatic logic [LANE_WIDTH-1:0] rotate(input logic [LANE_WIDTH-1:0] r);
        if (DIR == 1'b0)
            rotate = {r[LANE_WIDTH-2:0], r[LANE_WIDTH-1]};
        else
            rotate = {r[0], r[LANE_WIDTH-1:1]};
    endfunction

    // Next-state and next-output decode; priority load > collision > pause > tick.
    always_comb begin
        state_p0 = state_p1;
        row_p0   = row_p1;
        hit_p0   = hit_p1;
        step_p0  = 1'b0;
        if (bus.SC_LANE_LOAD_In) begin
            row_p0   = bus.SC_LANE_PATTERN_In;
            hit_p0   = 1'b0;
            state_p0 = RUN;
        end else begin
            case (state_p1)
                RUN: begin
                    if ((row_p1 & bus.SC_LANE_FROG_In) != '0) begin
                        hit_p0   = 1'b1;
                        state_p0 = HALT;
                    end else if (bus.SC_LANE_PAUSE_In) begin
                        state_p0 = PAUSED;
                    end else if (bus.SC_LANE_TICK_In) begin
                        row_p0  = rotate(row_p1);
                        step_p0 = 1'b1;
                    end
                end
                PAUSED: begin
                    if (!bus.SC_LANE_PAUSE_In)
                        state_p0 = RUN;
                end
                default: ;
            endcase
        end
    end

    // Registered state and outputs.
    always_ff @(posedge SC_LANE_CLOCK_50) begin
        if (SC_LANE_RESET) begin
            state_p1 <= IDLE;
            row_p1   <= INIT_PATTERN;
            hit_p1   <= 1'b0;
            step_p1  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            row_p1   <= row_p0;
            hit_p1   <= hit_p0;
            step_p1  <= step_p0;
        end
    end

    assign bus.SC_LANE_Out       = row_p1;
    assign bus.SC_LANE_HIT_Out   = hit_p1;
    assign bus.SC_LANE_STEP_Out  = step_p1;
    assign bus.SC_LANE_STATE_Out = state_p1;

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Directed bench for sc_lane_shifter: DIR=0 lane under test plus a DIR=1 lane
// fed the same inputs to check the opposite rotation.
module tb_sc_lane_shifter;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    logic [11:0] snap;

    sc_lane_shifter_if #(.LANE_WIDTH(8)) L0 ();
    sc_lane_shifter_if #(.LANE_WIDTH(8)) L1 ();

    sc_lane_shifter #(.LANE_WIDTH(8), .DIR(1'b0), .INIT_PATTERN(8'h03)) dut0 (
        .SC_LANE_CLOCK_50(clk),
        .SC_LANE_RESET   (rst),
        .bus             (L0.slave)
    );

    sc_lane_shifter #(.LANE_WIDTH(8), .DIR(1'b1), .INIT_PATTERN(8'h03)) dut1 (
        .SC_LANE_CLOCK_50(clk),
        .SC_LANE_RESET   (rst),
        .bus             (L1.slave)
    );

    assign L1.SC_LANE_TICK_In    = L0.SC_LANE_TICK_In;
    assign L1.SC_LANE_LOAD_In    = L0.SC_LANE_LOAD_In;
    assign L1.SC_LANE_PATTERN_In = L0.SC_LANE_PATTERN_In;
    assign L1.SC_LANE_PAUSE_In   = L0.SC_LANE_PAUSE_In;
    assign L1.SC_LANE_FROG_In    = L0.SC_LANE_FROG_In;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Packs {Out, HIT, STEP, STATE} of the DIR=0 lane.
    function automatic logic [11:0] pk();
        pk = {L0.SC_LANE_Out, L0.SC_LANE_HIT_Out, L0.SC_LANE_STEP_Out, L0.SC_LANE_STATE_Out};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] pat, input logic tk,
                         input logic ps, input logic [7:0] fr);
        L0.SC_LANE_LOAD_In    = ld;
        L0.SC_LANE_PATTERN_In = pat;
        L0.SC_LANE_TICK_In    = tk;
        L0.SC_LANE_PAUSE_In   = ps;
        L0.SC_LANE_FROG_In    = fr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc();
        rst = 1'b0;
        snap = pk(); total++;
        if (snap !== {8'h03, 1'b0, 1'b0, 2'b00})
            $display("FAIL reset_state: got %h want %h", snap, {8'h03, 1'b0, 1'b0, 2'b00});
        else passed++;
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            cyc();
            snap = pk(); total++;
            if (snap !== {8'h03, 1'b0, 1'b0, 2'b00})
                $display("FAIL idle_ignore_%0d: got %h want %h", i, snap, {8'h03, 1'b0, 1'b0, 2'b00});
            else passed++;
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_row [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        drive(1'b1, 8'h81, 1'b0, 1'b0, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h81, 1'b0, 1'b0, 2'b01})
            $display("FAIL load_81: got %h want %h", snap, {8'h81, 1'b0, 1'b0, 2'b01});
        else passed++;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h03, 1'b0, 1'b1, 2'b01})
            $display("FAIL first_tick: got %h want %h", snap, {8'h03, 1'b0, 1'b1, 2'b01});
        else passed++;
        total++;
        if (L1.SC_LANE_Out !== 8'hC0)
            $display("FAIL dir1_tick: got %h want %h", L1.SC_LANE_Out, 8'hC0);
        else passed++;
        L0.SC_LANE_TICK_In = 1'b0;
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h03, 1'b0, 1'b0, 2'b01})
            $display("FAIL step_one_cycle: got %h want %h", snap, {8'h03, 1'b0, 1'b0, 2'b01});
        else passed++;
        L0.SC_LANE_TICK_In = 1'b1;
        for (int i = 1; i < 8; i++) begin
            cyc();
            snap = pk(); total++;
            if (snap !== {exp_row[i], 1'b0, 1'b1, 2'b01})
                $display("FAIL rotate_%0d: got %h want %h", i, snap, {exp_row[i], 1'b0, 1'b1, 2'b01});
            else passed++;
        end
        total++;
        if (L1.SC_LANE_Out !== 8'h81)
            $display("FAIL dir1_wrap: got %h want %h", L1.SC_LANE_Out, 8'h81);
        else passed++;
        L0.SC_LANE_TICK_In = 1'b0;
    endtask

    task automatic test_pause();
        drive(1'b1, 8'h06, 1'b0, 1'b0, 8'h00);
        cyc();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h06, 1'b0, 1'b0, 2'b10})
            $display("FAIL pause_enter: got %h want %h", snap, {8'h06, 1'b0, 1'b0, 2'b10});
        else passed++;
        L0.SC_LANE_FROG_In = 8'h06;
        for (int i = 0; i < 2; i++) begin
            cyc();
            snap = pk(); total++;
            if (snap !== {8'h06, 1'b0, 1'b0, 2'b10})
                $display("FAIL pause_hold_%0d: got %h want %h", i, snap, {8'h06, 1'b0, 1'b0, 2'b10});
            else passed++;
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h06, 1'b0, 1'b0, 2'b01})
            $display("FAIL pause_release: got %h want %h", snap, {8'h06, 1'b0, 1'b0, 2'b01});
        else passed++;
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h0C, 1'b0, 1'b1, 2'b01})
            $display("FAIL after_release: got %h want %h", snap, {8'h0C, 1'b0, 1'b1, 2'b01});
        else passed++;
        drive(1'b1, 8'h55, 1'b0, 1'b1, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h55, 1'b0, 1'b0, 2'b01})
            $display("FAIL load_ignores_pause: got %h want %h", snap, {8'h55, 1'b0, 1'b0, 2'b01});
        else passed++;
        L0.SC_LANE_LOAD_In = 1'b0;
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h55, 1'b0, 1'b0, 2'b10})
            $display("FAIL pause_after_load: got %h want %h", snap, {8'h55, 1'b0, 1'b0, 2'b10});
        else passed++;
        L0.SC_LANE_PAUSE_In = 1'b0;
        cyc();
    endtask

    task automatic test_collision();
        drive(1'b1, 8'h06, 1'b0, 1'b0, 8'h00);
        cyc();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h04);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h06, 1'b1, 1'b0, 2'b11})
            $display("FAIL hit_enter: got %h want %h", snap, {8'h06, 1'b1, 1'b0, 2'b11});
        else passed++;
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            cyc();
            snap = pk(); total++;
            if (snap !== {8'h06, 1'b1, 1'b0, 2'b11})
                $display("FAIL halt_hold_%0d: got %h want %h", i, snap, {8'h06, 1'b1, 1'b0, 2'b11});
            else passed++;
        end
        drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h10, 1'b0, 1'b0, 2'b01})
            $display("FAIL halt_reload: got %h want %h", snap, {8'h10, 1'b0, 1'b0, 2'b01});
        else passed++;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h20);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h20, 1'b0, 1'b1, 2'b01})
            $display("FAIL no_overlap_rotate: got %h want %h", snap, {8'h20, 1'b0, 1'b1, 2'b01});
        else passed++;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h30);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h20, 1'b1, 1'b0, 2'b11})
            $display("FAIL multihot_over_pause: got %h want %h", snap, {8'h20, 1'b1, 1'b0, 2'b11});
        else passed++;
    endtask

    task automatic test_load_tick();
        drive(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
        cyc();
        snap = pk(); total++;
        if (snap !== {8'h55, 1'b0, 1'b0, 2'b01})
            $display("FAIL load_drops_tick: got %h want %h", snap, {8'h55, 1'b0, 1'b0, 2'b01});
        else passed++;
        L0.SC_LANE_LOAD_In = 1'b0;
        cyc();
        snap = pk(); total++;
        if (snap !== {8'hAA, 1'b0, 1'b1, 2'b01})
            $display("FAIL tick_after_load: got %h want %h", snap, {8'hAA, 1'b0, 1'b1, 2'b01});
        else passed++;
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 8'h06, 1'b0, 1'b0, 8'h00);
        cyc();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h04);
        cyc();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        snap = pk(); total++;
        if (snap !== {8'h03, 1'b0, 1'b0, 2'b00})
            $display("FAIL reset_midrun: got %h want %h", snap, {8'h03, 1'b0, 1'b0, 2'b00});
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc();
        test_reset();
        test_rotate();
        test_pause();
        test_collision();
        test_load_tick();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
